// File: rtl/commit_check_if.sv
// Expected-record and commit channels of the lockstep commit checker.
// The reference model and writeback stage drive the master side.
interface commit_check_if #(
  parameter int DATA_W = 16
);
  logic              exp_valid;
  logic              exp_ready;
  logic [DATA_W-1:0] exp_pc;
  logic [DATA_W-1:0] exp_instr;
  logic              exp_wr_en;
  logic [3:0]        exp_wr_reg;
  logic [DATA_W-1:0] exp_wr_data;
  logic              exp_mem_wr;
  logic [DATA_W-1:0] exp_mem_addr;
  logic [DATA_W-1:0] exp_mem_data;
  logic [2:0]        exp_flags;

  logic              cmt_valid;
  logic [DATA_W-1:0] cmt_pc;
  logic [DATA_W-1:0] cmt_instr;
  logic              cmt_wr_en;
  logic [3:0]        cmt_wr_reg;
  logic [DATA_W-1:0] cmt_wr_data;
  logic              cmt_mem_wr;
  logic [DATA_W-1:0] cmt_mem_addr;
  logic [DATA_W-1:0] cmt_mem_data;
  logic [2:0]        cmt_flags;
  logic              cmt_hlt;

  modport master (
    output exp_valid, exp_pc, exp_instr, exp_wr_en,
    output exp_wr_reg, exp_wr_data, exp_mem_wr,
    output exp_mem_addr, exp_mem_data, exp_flags,
    output cmt_valid, cmt_pc, cmt_instr, cmt_wr_en,
    output cmt_wr_reg, cmt_wr_data, cmt_mem_wr,
    output cmt_mem_addr, cmt_mem_data, cmt_flags,
    output cmt_hlt,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_pc, exp_instr, exp_wr_en,
    input  exp_wr_reg, exp_wr_data, exp_mem_wr,
    input  exp_mem_addr, exp_mem_data, exp_flags,
    input  cmt_valid, cmt_pc, cmt_instr, cmt_wr_en,
    input  cmt_wr_reg, cmt_wr_data, cmt_mem_wr,
    input  cmt_mem_addr, cmt_mem_data, cmt_flags,
    input  cmt_hlt,
    output exp_ready
  );
endinterface

// File: rtl/commit_check_unit.sv
// Lockstep commit checker: expected-record FIFO, field compare, watchdog.
// Define CHECK_FLAGS_EN to also compare the {Z,N,V} flags.
module commit_check_unit #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  commit_check_if.slave     bus,
  output logic              error,
  output logic [7:0]        err_field,
  output logic [DATA_W-1:0] first_err_pc,
  output logic [CNT_W-1:0]  commit_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [1:0]        state,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              wr_en;
    logic [3:0]        wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [2:0]        flags;
  } rec_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10,
    FAIL = 2'b11
  } st_e;

  st_e st_q, st_d;
  rec_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic error_q, error_d;
  logic [7:0] field_q, field_d;
  logic [DATA_W-1:0] fpc_q, fpc_d;
  logic [DATA_W-1:0] last_pc_q, last_pc_d;
  logic [CNT_W-1:0] ccnt_q, ccnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic active, empty, full;
  logic push, pop, chk;
  logic hlt_end, tmo;
  logic [7:0] cause;
  rec_t in_rec, act, head;

  assign empty = (cnt_q == '0);
  assign full = (cnt_q == (AW+1)'(DEPTH));
  assign head = mem_q[rd_ptr_q];

  always_comb begin : p_rec
    in_rec.pc       = bus.exp_pc;
    in_rec.instr    = bus.exp_instr;
    in_rec.wr_en    = bus.exp_wr_en;
    in_rec.wr_reg   = bus.exp_wr_reg;
    in_rec.wr_data  = bus.exp_wr_data;
    in_rec.mem_wr   = bus.exp_mem_wr;
    in_rec.mem_addr = bus.exp_mem_addr;
    in_rec.mem_data = bus.exp_mem_data;
    act.pc          = bus.cmt_pc;
    act.instr       = bus.cmt_instr;
    act.wr_en       = bus.cmt_wr_en;
    act.wr_reg      = bus.cmt_wr_reg;
    act.wr_data     = bus.cmt_wr_data;
    act.mem_wr      = bus.cmt_mem_wr;
    act.mem_addr    = bus.cmt_mem_addr;
    act.mem_data    = bus.cmt_mem_data;
`ifdef CHECK_FLAGS_EN
    in_rec.flags    = bus.exp_flags;
    act.flags       = bus.cmt_flags;
`else
    in_rec.flags    = 3'b000;
    act.flags       = 3'b000;
`endif
  end

  always_comb begin : p_out
    active        = (st_q == IDLE) || (st_q == RUN);
    bus.exp_ready = active && !full;
    done          = !active;
  end

  always_comb begin : p_dp
    push = bus.exp_valid && bus.exp_ready;
    chk  = bus.cmt_valid && active;
    pop  = chk && !empty;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + (AW+1)'(1);
    if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);

    wd_d = '0;
    if (st_q == RUN && !bus.cmt_valid) wd_d = wd_q + WW'(1);
    tmo = (st_q == RUN) && !bus.cmt_valid &&
          (wd_d == WW'(TIMEOUT));
    hlt_end = chk && (st_q == RUN) && bus.cmt_hlt;

    cause = '0;
    if (chk && empty) begin
      cause[5] = 1'b1;
    end else if (chk) begin
      cause[0] = head.pc != act.pc;
      cause[1] = head.instr != act.instr;
      cause[2] = (head.wr_en != act.wr_en) ||
                 (head.wr_en && act.wr_en &&
                  ((head.wr_reg != act.wr_reg) ||
                   (head.wr_data != act.wr_data)));
      cause[3] = (head.mem_wr != act.mem_wr) ||
                 (head.mem_wr && act.mem_wr &&
                  ((head.mem_addr != act.mem_addr) ||
                   (head.mem_data != act.mem_data)));
      cause[4] = head.flags != act.flags;
    end
    cause[6] = tmo;
    cause[7] = hlt_end && (cnt_d != '0);

    error_d = error_q || (|cause);
    field_d = field_q | cause;
    fpc_d = fpc_q;
    // Timeout has no commit of its own; blame the last retired PC.
    if (!error_q && (|cause)) fpc_d = tmo ? last_pc_q : bus.cmt_pc;
    last_pc_d = chk ? bus.cmt_pc : last_pc_q;

    ccnt_d = ccnt_q;
    if (chk && ccnt_q != '1) ccnt_d = ccnt_q + CNT_W'(1);
    mcnt_d = mcnt_q;
    if ((|cause[5:0]) && mcnt_q != '1) mcnt_d = mcnt_q + CNT_W'(1);
  end

  always_comb begin : p_next
    st_d = st_q;
    unique case (st_q)
      IDLE: if (push || chk) st_d = RUN;
      RUN: begin
        if (hlt_end) st_d = (cnt_d == '0 && !error_d) ? DONE : FAIL;
        else if (tmo) st_d = FAIL;
      end
      default: st_d = st_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : p_st
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_ff @(posedge clk or posedge rst) begin : p_reg
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      wd_q      <= '0;
      error_q   <= 1'b0;
      field_q   <= '0;
      fpc_q     <= '0;
      last_pc_q <= '0;
      ccnt_q    <= '0;
      mcnt_q    <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= in_rec;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      error_q   <= error_d;
      field_q   <= field_d;
      fpc_q     <= fpc_d;
      last_pc_q <= last_pc_d;
      ccnt_q    <= ccnt_d;
      mcnt_q    <= mcnt_d;
    end
  end

  assign error        = error_q;
  assign err_field    = field_q;
  assign first_err_pc = fpc_q;
  assign commit_cnt   = ccnt_q;
  assign mismatch_cnt = mcnt_q;
  assign state        = st_q;

endmodule

// File: tb/tb_commit_check_unit.sv
// Directed bench for commit_check_unit with a commit-result scoreboard.
// Flag expectations follow CHECK_FLAGS_EN when it is defined.
module tb_commit_check_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        error;
  logic [7:0]  err_field;
  logic [15:0] first_err_pc;
  logic [15:0] commit_cnt;
  logic [15:0] mismatch_cnt;
  logic [1:0]  state;
  logic        done;

  int ntot = 0;
  int npass = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  commit_check_if #(.DATA_W(16)) bus ();

  commit_check_unit #(
    .DATA_W(16), .DEPTH(8), .TIMEOUT(64), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .error(error),
    .err_field(err_field),
    .first_err_pc(first_err_pc),
    .commit_cnt(commit_cnt),
    .mismatch_cnt(mismatch_cnt),
    .state(state),
    .done(done)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic        we;
    logic [3:0]  rg;
    logic [15:0] wd;
    logic        mw;
    logic [15:0] ma;
    logic [15:0] md;
    logic [2:0]  fl;
  } rec_t;

  typedef struct {
    string       tag;
    logic        err;
    logic [7:0]  fld;
    logic [15:0] cc;
    logic [15:0] mc;
    logic [1:0]  st;
  } exp_t;

  exp_t sb[$];

  function automatic rec_t rec_of(input int i);
    rec_t r;
    r.pc = 16'(2 * i);
    r.instr = 16'h1000 + 16'(i);
    r.we = 1'b1;
    r.rg = 4'(i);
    r.wd = 16'hA000 ^ 16'(i);
    r.mw = 1'(i);
    r.ma = 16'h0100 + 16'(i);
    r.md = 16'h5500 + 16'(i);
    r.fl = 3'(i);
    return r;
  endfunction

  function automatic exp_t mk_exp(input string tag, input logic e,
      input logic [7:0] f, input int cc, input int mc,
      input logic [1:0] st);
    exp_t x;
    x.tag = tag; x.err = e; x.fld = f;
    x.cc = 16'(cc); x.mc = 16'(mc); x.st = st;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_exp(input rec_t r);
    bus.exp_valid = 1'b1;
    bus.exp_pc = r.pc; bus.exp_instr = r.instr;
    bus.exp_wr_en = r.we; bus.exp_wr_reg = r.rg;
    bus.exp_wr_data = r.wd; bus.exp_mem_wr = r.mw;
    bus.exp_mem_addr = r.ma; bus.exp_mem_data = r.md;
    bus.exp_flags = r.fl;
  endtask

  task automatic push_rec(input rec_t r);
    drive_exp(r);
    tick();
    bus.exp_valid = 1'b0;
  endtask

  task automatic check_sb;
    exp_t x;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk({x.tag, "_err"}, 32'(error), 32'(x.err));
      chk({x.tag, "_fld"}, 32'(err_field), 32'(x.fld));
      chk({x.tag, "_ccnt"}, 32'(commit_cnt), 32'(x.cc));
      chk({x.tag, "_mcnt"}, 32'(mismatch_cnt), 32'(x.mc));
      chk({x.tag, "_st"}, 32'(state), 32'(x.st));
    end
  endtask

  task automatic commit_step(input rec_t r, input logic hlt,
                             input exp_t x);
    sb.push_back(x);
    bus.cmt_valid = 1'b1;
    bus.cmt_pc = r.pc; bus.cmt_instr = r.instr;
    bus.cmt_wr_en = r.we; bus.cmt_wr_reg = r.rg;
    bus.cmt_wr_data = r.wd; bus.cmt_mem_wr = r.mw;
    bus.cmt_mem_addr = r.ma; bus.cmt_mem_data = r.md;
    bus.cmt_flags = r.fl; bus.cmt_hlt = hlt;
    tick();
    bus.cmt_valid = 1'b0;
    bus.cmt_hlt = 1'b0;
    bus.exp_valid = 1'b0;
    check_sb();
  endtask

  task automatic do_reset;
    bus.exp_valid = 1'b0;
    bus.cmt_valid = 1'b0;
    bus.cmt_hlt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin : stim
    rec_t r;
    rec_t c;
    drive_exp(rec_of(0));
    bus.exp_valid = 1'b0;
    bus.cmt_valid = 1'b0;
    bus.cmt_hlt = 1'b0;
    bus.cmt_pc = '0; bus.cmt_instr = '0;
    bus.cmt_wr_en = 1'b0; bus.cmt_wr_reg = '0;
    bus.cmt_wr_data = '0; bus.cmt_mem_wr = 1'b0;
    bus.cmt_mem_addr = '0; bus.cmt_mem_data = '0;
    bus.cmt_flags = '0;

    // Clean program ending in HLT
    do_reset();
    chk("rst_ready", 32'(bus.exp_ready), 32'd1);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_ccnt", 32'(commit_cnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) push_rec(rec_of(i));
    chk("t1_run", 32'(state), 32'd1);
    for (int i = 0; i < 4; i++)
      commit_step(rec_of(i), i == 3,
        mk_exp("t1_c", 1'b0, 8'h00, i + 1, 0, (i == 3) ? 2'd2 : 2'd1));
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_ready", 32'(bus.exp_ready), 32'd0);

    // Field mismatches
    do_reset();
    r = rec_of(0);
    r.pc = 16'h0010; r.we = 1'b1; r.rg = 4'd3; r.wd = 16'h1234;
    r.mw = 1'b0;
    push_rec(r);
    c = r; c.wd = 16'h1235;
    commit_step(c, 1'b0, mk_exp("t2_reg", 1'b1, 8'h04, 1, 1, 2'd1));
    chk("t2_fpc", 32'(first_err_pc), 32'h0010);
    r.pc = 16'h0012; r.we = 1'b0; r.mw = 1'b1;
    r.ma = 16'h0040; r.md = 16'h0055;
    push_rec(r);
    c = r; c.md = 16'h0056;
    commit_step(c, 1'b0, mk_exp("t2_mem", 1'b1, 8'h0C, 2, 2, 2'd1));
    r.pc = 16'h0014; r.we = 1'b0; r.wd = 16'hAAAA; r.mw = 1'b0;
    push_rec(r);
    c = r; c.wd = 16'hBBBB; c.rg = 4'd9; c.ma = 16'h7777;
    commit_step(c, 1'b0, mk_exp("t2_nowr", 1'b1, 8'h0C, 3, 2, 2'd1));
    chk("t2_fpc_hold", 32'(first_err_pc), 32'h0010);

    // Underflow with same-cycle push; pushed record survives
    do_reset();
    r = rec_of(5);
    drive_exp(r);
    c = rec_of(24);
    commit_step(c, 1'b0, mk_exp("t3_uf", 1'b1, 8'h20, 1, 1, 2'd1));
    chk("t3_fpc", 32'(first_err_pc), 32'h0030);
    c = r; c.fl = r.fl ^ 3'b111;
`ifdef CHECK_FLAGS_EN
    commit_step(c, 1'b0, mk_exp("t3_kept", 1'b1, 8'h30, 2, 2, 2'd1));
`else
    commit_step(c, 1'b0, mk_exp("t3_kept", 1'b1, 8'h20, 2, 1, 2'd1));
`endif

    // Full FIFO, dropped push, pointer wrap over 20 records
    do_reset();
    for (int i = 0; i < 8; i++) push_rec(rec_of(i));
    chk("t4_full", 32'(bus.exp_ready), 32'd0);
    r = rec_of(0); r.pc = 16'h0900;
    push_rec(r);
    chk("t4_full2", 32'(bus.exp_ready), 32'd0);
    commit_step(rec_of(0), 1'b0, mk_exp("t4_c0", 1'b0, 8'h00, 1, 0, 2'd1));
    chk("t4_ready", 32'(bus.exp_ready), 32'd1);
    for (int i = 1; i < 20; i++) begin
      if (i + 7 <= 19) drive_exp(rec_of(i + 7));
      commit_step(rec_of(i), 1'b0,
        mk_exp("t4_wrap", 1'b0, 8'h00, i + 1, 0, 2'd1));
    end
    commit_step(r, 1'b0, mk_exp("t4_drop", 1'b1, 8'h20, 21, 1, 2'd1));
    chk("t4_fpc", 32'(first_err_pc), 32'h0900);

    // Watchdog expiry
    do_reset();
    push_rec(rec_of(3));
    repeat (63) tick();
    chk("t5_pre", 32'(state), 32'd1);
    tick();
    chk("t5_state", 32'(state), 32'd3);
    chk("t5_fld", 32'(err_field), 32'h40);
    chk("t5_err", 32'(error), 32'd1);
    chk("t5_fpc", 32'(first_err_pc), 32'h0000);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_ready", 32'(bus.exp_ready), 32'd0);
    commit_step(rec_of(3), 1'b0, mk_exp("t5_ign", 1'b1, 8'h40, 0, 0, 2'd3));

    // HLT with leftover records, then async reset mid-FAIL
    do_reset();
    for (int i = 4; i < 7; i++) push_rec(rec_of(i));
    commit_step(rec_of(4), 1'b1, mk_exp("t6_left", 1'b1, 8'h80, 1, 0, 2'd3));
    chk("t6_fpc", 32'(first_err_pc), 32'h0008);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_r_state", 32'(state), 32'd0);
    chk("t6_r_err", 32'(error), 32'd0);
    chk("t6_r_fld", 32'(err_field), 32'd0);
    chk("t6_r_ccnt", 32'(commit_cnt), 32'd0);
    chk("t6_r_mcnt", 32'(mismatch_cnt), 32'd0);
    chk("t6_r_fpc", 32'(first_err_pc), 32'd0);
    chk("t6_r_ready", 32'(bus.exp_ready), 32'd1);
    chk("t6_r_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
